cpu_pixel_out_fifo_pio: RTL
===========================

Name: cpu_pixel_out_fifo_pio

Overview:
- Avalon-MM slave output port: the CPU writes 32-bit words, which are queued in a small FIFO.
- The FIFO presents those words to the classifier datapath over a valid/ready stream.
- It is the write-direction counterpart of the read-only input PIOs on the CPU bus.
- Status and control registers let software poll occupancy, detect drops and flush the queue.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (legal range 1..4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data, read latency 1 cycle.
- out_data  output  32  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
Register map:
- addr 0 DATA
  - Write: push writedata.
  - Read: last word accepted into the FIFO (0 after reset).
- addr 1 STATUS (read-only)
  - bits [DEPTH_LOG2:0] = count.
  - bit 8 = empty, bit 9 = full, bit 10 = overflow (sticky).
  - All other bits 0.
- addr 2 CONTROL (write-only, reads 0)
  - bit0 = flush, bit1 = clear overflow. Both are self-clearing actions.
- addr 3: reads 0; writes ignored.

Read path:
- readdata updates every clock, independent of chipselect, with the selected register value sampled from pre-edge state.

Reset (reset_n low at a clock edge):
- count=0, pointers=0, overflow=0, last-data=0, readdata=0.
- Consequently out_valid=0 and empty=1. FIFO contents are don't-care.
- Reset mid-transfer discards all queued words.

Push/pop:
- wr_req = chipselect & ~write_n & address==0.
- pop = out_valid & out_ready.
- push = wr_req & (~full | pop), where full and pop are evaluated on pre-edge state.
- push & pop in the same cycle: count unchanged, both pointers advance.
- Push when full with no pop: word dropped, overflow set to 1, count and pointers unchanged, last-data unchanged.
- Push when empty: out_valid rises the next cycle. Write-to-out_valid latency is 1 cycle; there is no bypass.

Output stream:
- out_data = mem[rd_ptr], driven combinationally from storage.
- out_data and out_valid stay stable while out_valid & ~out_ready.
- Pointers wrap modulo depth.
- count ranges 0..depth; full = (count==depth), empty = (count==0).

Control and simultaneous events:
- Flush sets count and pointers to 0. A concurrent pop is discarded.
- Flush has priority over any concurrent DATA write; that write is not counted as overflow.
- Clear-overflow and an overflowing push in the same cycle: overflow ends at 1 (set wins).
- Flush does not clear overflow or last-data.

Test Plan:
- Reset, then read STATUS: readdata=0x00000100 one cycle after the read address; out_valid=0.
- Write 0xA, 0xB, 0xC with out_ready=0: STATUS count=3; out_data=0xA; out_valid goes high 1 cycle after the first write.
- Write 5 words 0x1..0x5 at DEPTH_LOG2=2 with out_ready=0:
  - STATUS=0x00000604 (full, overflow, count 4).
  - DATA reads 0x4.
  - Draining yields 1, 2, 3, 4.
- FIFO full; write 0x9 with out_ready=1 in the same cycle: 0x1 popped, 0x9 accepted, count stays 4, overflow unchanged.
- Write CONTROL=0x3 while holding 3 words: count=0, out_valid=0 the next cycle, overflow cleared. A same-cycle DATA write is impossible (single address), so also check that flush followed immediately by a write gives count=1.
- Assert reset_n=0 for one edge with 2 words queued and out_ready toggling: all state cleared; the next pop sequence starts from new writes only.

Source files
------------

// File: rtl/cpu_pixel_out_fifo_pio_if.sv
// CPU-side Avalon-MM slave port plus the downstream pixel stream
// for the pixel output FIFO PIO.
interface cpu_pixel_out_fifo_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cpu_pixel_out_fifo_pio.sv
// CPU-written output FIFO: Avalon-MM writes queue 32-bit words
// that drain to the classifier datapath over valid/ready.
module cpu_pixel_out_fifo_pio #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    cpu_pixel_out_fifo_pio_if.slave     bus
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [31:0]           last_data;
    logic [31:0]           readdata_q;

    logic        wr_sel;
    logic        wr_req;
    logic        ctrl_wr;
    logic        flush;
    logic        clr_ovf;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;
    logic [31:0] status;

    assign wr_sel  = bus.chipselect & ~bus.write_n;
    assign wr_req  = wr_sel & (bus.address == A_DATA);
    assign ctrl_wr = wr_sel & (bus.address == A_CTRL);
    assign flush   = ctrl_wr & bus.writedata[0];
    assign clr_ovf = ctrl_wr & bus.writedata[1];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop frees a slot in the same edge, so a full FIFO can still
    // accept a word when the head is being consumed.
    assign pop  = ~empty & bus.out_ready;
    assign push = wr_req & ~flush & (~full | pop);
    assign drop = wr_req & ~flush & full & ~pop;

    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.readdata  = readdata_q;

    // Status word: count in the low bits, flags at 8..10.
    always_comb begin
        status               = '0;
        status[DEPTH_LOG2:0] = count;
        status[8]            = empty;
        status[9]            = full;
        status[10]           = overflow;
    end

    // Storage only; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.writedata;
        end
    end

    // Pointers and occupancy; flush discards any concurrent pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Last word actually accepted into the queue.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_data <= '0;
        end else if (push) begin
            last_data <= bus.writedata;
        end
    end

    // Read mux registered every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            unique case (bus.address)
                A_DATA:   readdata_q <= last_data;
                A_STATUS: readdata_q <= status;
                A_CTRL:   readdata_q <= '0;
                A_RSVD:   readdata_q <= '0;
                default:  readdata_q <= '0;
            endcase
        end
    end

endmodule
